// File: rtl/riscv_defines.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : riscv_defines                                                |
// | Description : Shared core definitions. Holds the TPR update sequencer      |
// |               state encoding and the architectural TPR reset value.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package riscv_defines;

  // TPR update sequencer states
  typedef enum logic [1:0] {
    TPR_UPD_IDLE   = 2'd0,
    TPR_UPD_DRAIN  = 2'd1,
    TPR_UPD_COMMIT = 2'd2
  } tpr_upd_state_e;

  // All tag modes decode to ALU_MODE_OLD (encoding 0) after reset
  localparam logic [31:0] TPR_RESET_VAL = 32'h0000_0000;

endpackage : riscv_defines
`default_nettype wire

// File: rtl/riscv_rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_rr_arbiter2                                            |
// | Description : Two-input round-robin arbiter with combinational grant.      |
// |               The priority pointer only moves when a grant is issued       |
// |               while both inputs are requesting, so a lone requester never  |
// |               steals the turn of the other one.                            |
// | Ports       : clk, rst     - clock, synchronous active-high reset          |
// |               en_i         - grants allowed this cycle                     |
// |               req_i[1:0]   - request vector                                |
// |               gnt_o[1:0]   - one-hot (or zero) grant vector                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riscv_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q == 0 : input 0 wins a tie; ptr_q == 1 : input 1 wins a tie
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11: begin
          gnt_o = ptr_q ? 2'b10 : 2'b01;
          ptr_d = ~ptr_q;
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : riscv_rr_arbiter2
`default_nettype wire

// File: rtl/riscv_tpr_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_tpr_update_ctrl                                        |
// | Description : Sequences writes to the Tag Propagation Register. Arbitrates |
// |               the CSR path and the debug unit, halts ID issue and waits    |
// |               for EX/WB to drain before the new TPR value becomes visible, |
// |               so no in-flight instruction sees a mix of old and new modes. |
// | Ports       : clk, rst                - clock, sync active-high reset      |
// |               csr_req_i/csr_wdata_i   - CSR write request and data         |
// |               csr_gnt_o               - CSR request accepted this cycle    |
// |               dbg_req_i/dbg_wdata_i   - debug write request and data       |
// |               dbg_gnt_o               - debug request accepted this cycle  |
// |               ex_busy_i               - instruction still in EX or WB      |
// |               halt_id_o               - stall ID while update pending      |
// |               tpr_o                   - committed TPR                      |
// |               tpr_update_o            - pulse on first cycle of new tpr_o  |
// |               busy_o                  - update in progress                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riscv_tpr_update_ctrl
  import riscv_defines::*;
#(
  parameter int unsigned             TPR_WIDTH    = 32,
  parameter int unsigned             DRAIN_CYCLES = 2,
  parameter logic [TPR_WIDTH-1:0]    TPR_RESET    = TPR_WIDTH'(TPR_RESET_VAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_req_i,
  input  logic [TPR_WIDTH-1:0] csr_wdata_i,
  output logic                 csr_gnt_o,
  input  logic                 dbg_req_i,
  input  logic [TPR_WIDTH-1:0] dbg_wdata_i,
  output logic                 dbg_gnt_o,
  input  logic                 ex_busy_i,
  output logic                 halt_id_o,
  output logic [TPR_WIDTH-1:0] tpr_o,
  output logic                 tpr_update_o,
  output logic                 busy_o
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  tpr_upd_state_e       state_q, state_d;
  logic [3:0]           cnt_q,   cnt_d;
  logic [TPR_WIDTH-1:0] pend_q,  pend_d;
  logic [TPR_WIDTH-1:0] tpr_q,   tpr_d;
  logic                 upd_q,   upd_d;
  logic                 halt_q,  halt_d;

  logic                 arb_en;
  logic [1:0]           arb_gnt;
  logic [TPR_WIDTH-1:0] gnt_wdata;

  // Grants only while idle; suppressed during reset so nothing is accepted
  // into a sequencer that is being cleared.
  assign arb_en = (state_q == TPR_UPD_IDLE) && !rst;

  riscv_rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i ({dbg_req_i, csr_req_i}),
    .gnt_o (arb_gnt)
  );

  assign csr_gnt_o = arb_gnt[0];
  assign dbg_gnt_o = arb_gnt[1];
  assign gnt_wdata = arb_gnt[1] ? dbg_wdata_i : csr_wdata_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    tpr_d   = tpr_q;
    upd_d   = 1'b0;

    case (state_q)
      TPR_UPD_IDLE: begin
        // A write of the value already held is acknowledged but needs no
        // pipeline drain: the decoder would see no change anyway.
        if ((arb_gnt != 2'b00) && (gnt_wdata != tpr_q)) begin
          pend_d  = gnt_wdata;
          cnt_d   = DRAIN_LOAD;
          state_d = TPR_UPD_DRAIN;
        end
      end

      TPR_UPD_DRAIN: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if ((cnt_q == 4'd0) && !ex_busy_i) begin
          state_d = TPR_UPD_COMMIT;
        end
      end

      TPR_UPD_COMMIT: begin
        tpr_d   = pend_q;
        upd_d   = 1'b1;
        state_d = TPR_UPD_IDLE;
      end

      default: state_d = TPR_UPD_IDLE;
    endcase

    // Registered halt tracks the state the FSM is entering, so it is high in
    // exactly the cycles spent in DRAIN or COMMIT.
    halt_d = (state_d != TPR_UPD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TPR_UPD_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= '0;
      tpr_q   <= TPR_RESET;
      upd_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      tpr_q   <= tpr_d;
      upd_q   <= upd_d;
      halt_q  <= halt_d;
    end
  end

  assign tpr_o        = tpr_q;
  assign tpr_update_o = upd_q;
  assign halt_id_o    = halt_q;
  assign busy_o       = halt_q;

endmodule : riscv_tpr_update_ctrl
`default_nettype wire

// File: tb/tb_riscv_tpr_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_riscv_tpr_update_ctrl                                     |
// | Description : Self-checking bench for riscv_tpr_update_ctrl: a cycle table |
// |               for single and arbitrated updates, hand sequences for the    |
// |               multi-cycle corner cases, then random traffic against a      |
// |               timeline-based reference model.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_riscv_tpr_update_ctrl;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_req;
  logic [31:0] csr_wdata;
  logic        csr_gnt;
  logic        dbg_req;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        ex_busy;
  logic        halt_id;
  logic [31:0] tpr;
  logic        tpr_update;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_tpr_update_ctrl #(
    .TPR_WIDTH    (32),
    .DRAIN_CYCLES (D),
    .TPR_RESET    (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_req_i    (csr_req),
    .csr_wdata_i  (csr_wdata),
    .csr_gnt_o    (csr_gnt),
    .dbg_req_i    (dbg_req),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_gnt_o    (dbg_gnt),
    .ex_busy_i    (ex_busy),
    .halt_id_o    (halt_id),
    .tpr_o        (tpr),
    .tpr_update_o (tpr_update),
    .busy_o       (busy)
  );

  typedef struct {
    logic        creq;
    logic [31:0] cdat;
    logic        dreq;
    logic [31:0] ddat;
    logic        exb;
    logic        egc;
    logic        egd;
    logic        ehalt;
    logic        eupd;
    logic [31:0] etpr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic creq, logic [31:0] cdat, logic dreq, logic [31:0] ddat,
                              logic egc, logic egd, logic ehalt, logic eupd, logic [31:0] etpr);
    vec_t v;
    v.creq = creq; v.cdat = cdat; v.dreq = dreq; v.ddat = ddat; v.exb = 1'b0;
    v.egc = egc; v.egd = egd; v.ehalt = ehalt; v.eupd = eupd; v.etpr = etpr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the active edge and return while
  // outputs are settled, well before the next edge.
  task automatic step(input logic r, input logic cq, input logic [31:0] cd,
                      input logic dq, input logic [31:0] dd, input logic b);
    @(posedge clk);
    #1;
    rst = r; csr_req = cq; csr_wdata = cd; dbg_req = dq; dbg_wdata = dd; ex_busy = b;
    #3;
  endtask

  task automatic idle_step(input logic b);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, b);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Reference model: each accepted update is tracked by cycle numbers.
  // Accepted in cycle a -> halted from a+1; may leave drain at the first
  // cycle e >= a+1+D without ex_busy; commits in e+1; visible in e+2.
  logic [31:0] m_tpr;
  logic        m_pref;       // 0: CSR wins a tie, 1: debug wins a tie
  logic        m_active;
  logic [31:0] m_val;
  int          m_earliest;
  int          m_exit;
  int          m_upd_cycle;

  initial begin
    rst = 1'b1; csr_req = 1'b0; csr_wdata = '0; dbg_req = 1'b0; dbg_wdata = '0; ex_busy = 1'b0;

    // ---------------- table: reset state, test 1, test 2 -----------------
    tbl.push_back(mk(0, 32'h0,   0, 32'h0, 0, 0, 0, 0, 32'h0));       // reset state
    tbl.push_back(mk(1, 32'h155, 0, 32'h0, 1, 0, 0, 0, 32'h0));       // c0 grant
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 32'h0));       // c1..c4 halted
    tbl.push_back(mk(0, 32'h0,   0, 32'h0, 0, 0, 0, 1, 32'h155));     // c5 commit visible
    tbl.push_back(mk(1, 32'hA,   1, 32'hB, 1, 0, 0, 0, 32'h155));     // both: csr first
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 32'h0, 1, 32'hB, 0, 0, 1, 0, 32'h155));     // dbg waits
    tbl.push_back(mk(0, 32'h0,   1, 32'hB, 0, 1, 0, 1, 32'hA));       // c5: A visible, dbg granted
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0, 1, 0, 32'hA));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0, 0, 0, 0, 1, 32'hB));       // c10
    tbl.push_back(mk(0, 32'h0,   0, 32'h0, 0, 0, 0, 0, 32'hB));

    do_reset();
    foreach (tbl[k]) begin
      step(1'b0, tbl[k].creq, tbl[k].cdat, tbl[k].dreq, tbl[k].ddat, tbl[k].exb);
      chk($sformatf("tbl%0d csr_gnt", k), 32'(csr_gnt),    32'(tbl[k].egc));
      chk($sformatf("tbl%0d dbg_gnt", k), 32'(dbg_gnt),    32'(tbl[k].egd));
      chk($sformatf("tbl%0d halt", k),    32'(halt_id),    32'(tbl[k].ehalt));
      chk($sformatf("tbl%0d busy", k),    32'(busy),       32'(tbl[k].ehalt));
      chk($sformatf("tbl%0d upd", k),     32'(tpr_update), 32'(tbl[k].eupd));
      chk($sformatf("tbl%0d tpr", k),     tpr,             tbl[k].etpr);
    end

    // ---------------- ex_busy holds DRAIN ----------------
    step(1'b0, 1'b1, 32'h33, 1'b0, 32'h0, 1'b0);
    chk("busy_hold gnt", 32'(csr_gnt), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      idle_step(1'b1);
      chk($sformatf("busy_hold halt c%0d", i), 32'(halt_id), 32'd1);
      chk($sformatf("busy_hold tpr c%0d", i), tpr, 32'hB);
    end
    idle_step(1'b0);   // c7: busy just fell, still draining
    chk("busy_hold halt c7", 32'(halt_id), 32'd1);
    idle_step(1'b0);   // c8: commit cycle
    chk("busy_hold halt c8", 32'(halt_id), 32'd1);
    chk("busy_hold upd c8", 32'(tpr_update), 32'd0);
    chk("busy_hold tpr c8", tpr, 32'hB);
    idle_step(1'b0);   // c9
    chk("busy_hold tpr c9", tpr, 32'h33);
    chk("busy_hold upd c9", 32'(tpr_update), 32'd1);
    chk("busy_hold halt c9", 32'(halt_id), 32'd0);

    // ---------------- silent debug write ----------------
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h33, 1'b0);
    chk("silent gnt", 32'(dbg_gnt), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      idle_step(1'b0);
      chk($sformatf("silent halt c%0d", i), 32'(halt_id), 32'd0);
      chk($sformatf("silent upd c%0d", i), 32'(tpr_update), 32'd0);
    end

    // ---------------- reset during DRAIN ----------------
    step(1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0);
    chk("rst_drain gnt", 32'(csr_gnt), 32'd1);
    idle_step(1'b0);
    chk("rst_drain halt", 32'(halt_id), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      idle_step(1'b0);
      chk($sformatf("rst_drain tpr c%0d", i),  tpr, 32'h0);
      chk($sformatf("rst_drain halt c%0d", i), 32'(halt_id), 32'd0);
      chk($sformatf("rst_drain busy c%0d", i), 32'(busy), 32'd0);
      chk($sformatf("rst_drain upd c%0d", i),  32'(tpr_update), 32'd0);
      chk($sformatf("rst_drain gnt c%0d", i),  32'(csr_gnt), 32'd0);
    end

    // ---------------- request withdrawn while busy ----------------
    begin
      int pulses;
      pulses = 0;
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h77, 1'b0);
      chk("withdraw dgnt", 32'(dbg_gnt), 32'd1);
      for (int i = 1; i <= 12; i++) begin
        step(1'b0, (i <= 2), 32'h88, 1'b0, 32'h0, 1'b0);
        chk($sformatf("withdraw cgnt c%0d", i), 32'(csr_gnt), 32'd0);
        if (tpr_update) pulses++;
      end
      chk("withdraw pulses", 32'(pulses), 32'd1);
      chk("withdraw tpr", tpr, 32'h77);
    end

    // ---------------- random traffic vs. model ----------------
    do_reset();
    m_tpr = 32'h0; m_pref = 1'b0; m_active = 1'b0; m_val = '0;
    m_earliest = 0; m_exit = -1; m_upd_cycle = -1;
    begin
      logic        cq, dq, b;
      logic [31:0] cd, dd;
      logic        egc, egd, was_active;
      cq = 1'b0; dq = 1'b0; cd = '0; dd = '0;
      for (int n = 0; n < 1500; n++) begin
        if (!cq && $urandom_range(3) == 0) begin
          cq = 1'b1; cd = ($urandom_range(3) == 0) ? m_tpr : $urandom;
        end else if (cq && $urandom_range(15) == 0) begin
          cq = 1'b0;
        end
        if (!dq && $urandom_range(3) == 0) begin
          dq = 1'b1; dd = ($urandom_range(3) == 0) ? m_tpr : $urandom;
        end else if (dq && $urandom_range(15) == 0) begin
          dq = 1'b0;
        end
        b = ($urandom_range(2) == 0);

        step(1'b0, cq, cd, dq, dd, b);

        egc = 1'b0; egd = 1'b0;
        if (!m_active) begin
          if (cq && dq) begin
            egc = !m_pref; egd = m_pref;
          end else begin
            egc = cq; egd = dq;
          end
        end

        chk($sformatf("rnd%0d csr_gnt", n), 32'(csr_gnt),    32'(egc));
        chk($sformatf("rnd%0d dbg_gnt", n), 32'(dbg_gnt),    32'(egd));
        chk($sformatf("rnd%0d halt", n),    32'(halt_id),    32'(m_active));
        chk($sformatf("rnd%0d busy", n),    32'(busy),       32'(m_active));
        chk($sformatf("rnd%0d upd", n),     32'(tpr_update), 32'(n == m_upd_cycle));
        chk($sformatf("rnd%0d tpr", n),     tpr,             m_tpr);

        was_active = m_active;
        if (m_active) begin
          if (m_exit < 0) begin
            if (n >= m_earliest && !b) m_exit = n;
          end else if (n == m_exit + 1) begin
            m_active    = 1'b0;
            m_tpr       = m_val;
            m_upd_cycle = n + 1;
          end
        end
        if (!was_active && (egc || egd)) begin
          if (cq && dq) m_pref = ~m_pref;
          if ((egd ? dd : cd) != m_tpr) begin
            m_active   = 1'b1;
            m_val      = egd ? dd : cd;
            m_earliest = n + 1 + D;
            m_exit     = -1;
          end
        end
        if (egc) cq = 1'b0;
        if (egd) dq = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_riscv_tpr_update_ctrl
`default_nettype wire
